// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bin2bcd_seq_if #(
    parameter int WORD_SIZE = 32,
    parameter int DIGITS    = 10
);
    logic                   start;
    logic [WORD_SIZE-1:0]   bin;
    logic                   busy;
    logic                   valid;
    logic [4*DIGITS-1:0]    bcd;

    modport master (output start, bin, input busy, valid, bcd);
    modport slave  (input start, bin, output busy, valid, bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble converter: one binary bit shifted into the BCD scratch per clock.
// Result and valid are registered; bcd only changes on a completed conversion.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; bcd holds the last result
// S_CONVERT | adjust-and-shift one bit per cycle, counter counts down
// S_DONE    | valid pulse for one cycle, then back to idle
module bin2bcd_seq #(
    parameter int WORD_SIZE    = 32,
    parameter int DIGITS       = 10,
    parameter int COUNTER_SIZE = 6
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam int         BCD_W     = 4 * DIGITS;

    logic [1:0]              r_state;
    logic [WORD_SIZE-1:0]    r_bin;
    logic [BCD_W-1:0]        r_scratch;
    logic [BCD_W-1:0]        r_bcd;
    logic [COUNTER_SIZE-1:0] r_count;
    logic                    r_busy;
    logic                    r_valid;
    logic [BCD_W-1:0]        w_adj;
    logic [BCD_W-1:0]        w_shifted;

    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
        end
    end

    // Digits shifted out of the top nibble are dropped: DIGITS sets the truncation.
    assign w_shifted = {w_adj[BCD_W-2:0], r_bin[WORD_SIZE-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin     <= bus.bin;
                        r_scratch <= '0;
                        r_count   <= COUNTER_SIZE'(WORD_SIZE);
                        r_busy    <= 1'b1;
                        r_state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_scratch <= w_shifted;
                    r_bin     <= {r_bin[WORD_SIZE-2:0], 1'b0};
                    r_count   <= r_count - COUNTER_SIZE'(1);
                    if (r_count == COUNTER_SIZE'(1)) begin
                        r_bcd   <= w_shifted;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign bus.bcd   = r_bcd;
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble (shift-and-add-3) converter that turns an unsigned binary word into packed BCD digits. It sits directly downstream of the FSMD divider: one instance converts `quotient` and a second converts `remainder` for the seven-segment display path on the Nexys 4 / Basys 3 boards. It converts one bit per clock and uses a start/busy/valid handshake, so it can be triggered from the divider's completion.

## Interface
- `WORD_SIZE`, default 32: width of the binary input.
- `DIGITS`, default 10: number of BCD output digits. The value must be at least ceil(WORD_SIZE·log10 2); 10 covers 32 bits.
- `COUNTER_SIZE`, default 6: width of the bit counter, equal to log2(WORD_SIZE)+1.

Ports:
- `clk`  in  1  system clock, rising edge, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `bin`  in  WORD_SIZE  unsigned binary operand; captured on the accepting edge.
- `busy`  out  1  high while in CONVERT or DONE.
- `valid`  out  1  one-cycle pulse when `bcd` has been updated.
- `bcd`  out  4·DIGITS  packed BCD. Digit 0 (units) is `bcd[3:0]`, and the most significant digit is in the top nibble.

## Operation
- Reset (rst=0, asynchronous) sets: state=IDLE, `bcd`=0, `valid`=0, `busy`=0, internal shift register=0, counter=0. The power-up `initial` values are the same.
- State machine:
  - IDLE: when `start`=1, capture `bin` into the binary shift register, clear the BCD scratch register, load counter=WORD_SIZE, and go to CONVERT. Otherwise stay in IDLE.
  - CONVERT: each cycle, first add 3 to every scratch digit ≥5 (combinational). Then shift {scratch, binary} left by one, feeding the binary MSB into scratch bit 0. Decrement the counter. On the cycle where counter=1, write the adjusted-and-shifted scratch value into `bcd` and go to DONE.
  - DONE: `valid`=1 for exactly this cycle, then go unconditionally to IDLE.
- `start` is ignored in CONVERT and DONE; it is not queued.
- Width rule: digits beyond DIGITS are truncated. No overflow flag is produced.
- `bcd` holds its last result until the next completion. It never shows partial scratch contents.
- Reset during CONVERT or DONE aborts the conversion and clears everything, `bcd` included.
- `bin` changes after the accepting edge have no effect on the conversion in progress.

## Timing
- If `start` is sampled at rising edge k in IDLE:
  - `busy` is high from edge k.
  - Shifts occur on edges k+1 … k+WORD_SIZE.
  - `bcd` updates and `valid` rises at edge k+WORD_SIZE.
  - `valid` and `busy` fall at edge k+WORD_SIZE+1.
- Latency from start to valid is WORD_SIZE cycles; this is 32 for the defaults.
- The earliest next accept is edge k+WORD_SIZE+2. With `start` held high, conversions repeat every WORD_SIZE+2 cycles (34).
- The design is fully synchronous except for `rst`. All outputs are registered.

## Test plan
- Reset then idle: assert rst=0 mid-cycle → `bcd`=0, `valid`=0, `busy`=0 immediately. After release with start=0 for 50 cycles, nothing changes.
- Basic: `bin`=1234, 1-cycle start → `valid` pulses exactly 32 cycles after the accepting edge, with `bcd`=0x0000001234. `bcd` holds after `valid` falls.
- Extremes: `bin`=0 → `bcd`=0x0000000000. `bin`=0xFFFFFFFF → `bcd`=0x4294967295. `bin`=0x3B9AC9FF (999999999) → 0x0999999999.
- Start while busy: a second start pulse with `bin`=7 at cycles 5 and 32 after acceptance of `bin`=42 → a single valid with 0x42. A held start yields valid pulses spaced 34 cycles apart.
- Reset mid-operation: after a previous result of 0x55, start `bin`=99 and assert rst=0 at cycle 10 → `bcd`=0 and IDLE with no `valid`. A new start with `bin`=99 after release → 0x99 after 32 cycles.
- Randomised sweep: 1000 random `bin` values compared against a reference decimal conversion. Also check that `bin` changes during CONVERT do not affect results.
